// File: rtl/tohost_pkg.sv
// Shared types and constants for the tohost completion monitor.
// The result characters are only consumed when TOHOST_UART_EN is defined.
package tohost_pkg;

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    DONE_PASS    = 2'd1,
    DONE_FAIL    = 2'd2,
    DONE_TIMEOUT = 2'd3
  } state_t;

  localparam logic [31:0] TOHOST_PASS_VAL = 32'h0000_0001;

  localparam logic [7:0] CHAR_PASS    = 8'h50;
  localparam logic [7:0] CHAR_FAIL    = 8'h46;
  localparam logic [7:0] CHAR_TIMEOUT = 8'h54;

  // Character reported on the UART for a terminal state
  function automatic logic [7:0] result_char(input state_t s);
    logic [7:0] c;
    case (s)
      DONE_PASS: c = CHAR_PASS;
      DONE_FAIL: c = CHAR_FAIL;
      default:   c = CHAR_TIMEOUT;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tohost_uart_tx.sv
// Minimal 8N1 transmitter that reports the test result character.
// Built only when TOHOST_UART_EN is defined.
`ifdef TOHOST_UART_EN
module tohost_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_START = 2'd1,
    U_DATA  = 2'd2,
    U_STOP  = 2'd3
  } ustate_t;

  ustate_t           ustate, ustate_next;
  logic [BAUD_W-1:0] baud, baud_next;
  logic [2:0]        bit_idx, bit_idx_next;
  logic [7:0]        shreg, shreg_next;
  logic              tx_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      ustate  <= U_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      ustate  <= ustate_next;
      baud    <= baud_next;
      bit_idx <= bit_idx_next;
      shreg   <= shreg_next;
      tx      <= tx_next;
      busy    <= (ustate_next != U_IDLE);
    end
  end

  // tx changes on the edge that enters each bit, so every bit spans BAUD_LAST+1 cycles
  always_comb begin
    ustate_next  = ustate;
    baud_next    = baud;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    tx_next      = tx;
    case (ustate)
      U_IDLE: begin
        tx_next = 1'b1;
        if (start) begin
          ustate_next = U_START;
          baud_next   = '0;
          shreg_next  = data;
          tx_next     = 1'b0;
        end
      end
      U_START: begin
        if (baud == BAUD_LAST) begin
          ustate_next  = U_DATA;
          baud_next    = '0;
          bit_idx_next = '0;
          tx_next      = shreg[0];
        end else begin
          baud_next = baud + BAUD_W'(1);
        end
      end
      U_DATA: begin
        if (baud == BAUD_LAST) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            ustate_next = U_STOP;
            tx_next     = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shreg_next   = shreg >> 1;
            tx_next      = shreg[1];
          end
        end else begin
          baud_next = baud + BAUD_W'(1);
        end
      end
      default: begin
        if (baud == BAUD_LAST) begin
          ustate_next = U_IDLE;
          baud_next   = '0;
          tx_next     = 1'b1;
        end else begin
          baud_next = baud + BAUD_W'(1);
        end
      end
    endcase
  end

endmodule
`endif

// File: rtl/tohost_monitor.sv
// Snoops core stores to tohost, latches pass/fail/test number and runs a cycle watchdog.
// Optional result UART on tx when TOHOST_UART_EN is defined.
module tohost_monitor
  import tohost_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 6000,
  parameter int unsigned CNT_W          = 32
`ifdef TOHOST_UART_EN
  ,
  parameter int unsigned CLKS_PER_BIT   = 868
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic             retire,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [30:0]      test_num,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
`ifdef TOHOST_UART_EN
  ,
  output logic             tx
`endif
);

  localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state, state_next;
  logic   hit_c;
  logic   wd_expire_c;

  assign hit_c       = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
  assign wd_expire_c = WD_EN && (cycle_count == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // A tohost hit takes priority over a watchdog expiry in the same cycle
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (hit_c)
          state_next = (mem_wdata == TOHOST_PASS_VAL) ? DONE_PASS : DONE_FAIL;
        else if (wd_expire_c)
          state_next = DONE_TIMEOUT;
      end
      default: state_next = state;
    endcase
  end

  // Result flags and counters update only while running; the hit cycle is still counted
  always_ff @(posedge clk) begin
    if (rst) begin
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      test_num      <= '0;
      cycle_count   <= '0;
      instret_count <= '0;
    end else if (state == RUN) begin
      done          <= (state_next != RUN);
      pass          <= (state_next == DONE_PASS);
      timeout       <= (state_next == DONE_TIMEOUT);
      cycle_count   <= cycle_count + CNT_W'(1);
      instret_count <= instret_count + CNT_W'(retire);
      if (state_next == DONE_FAIL) test_num <= mem_wdata[31:1];
    end
  end

`ifdef TOHOST_UART_EN
  logic       uart_start;
  logic       uart_busy;
  logic [7:0] uart_data_c;

  always_ff @(posedge clk) begin
    if (rst) uart_start <= 1'b0;
    else     uart_start <= (state == RUN) && (state_next != RUN);
  end

  assign uart_data_c = result_char(state);

  tohost_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst  (rst),
    .start(uart_start && !uart_busy),
    .data (uart_data_c),
    .tx   (tx),
    .busy (uart_busy)
  );
`endif

endmodule

// File: tb/tb_tohost_monitor.sv
// Self-checking bench for tohost_monitor: vector table, directed corner sequences,
// and randomized traffic against a reference model. Covers the UART when TOHOST_UART_EN is set.
module tb_tohost_monitor;
  localparam logic [31:0] ADDR = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        retire = 1'b0;

  logic        done_a, pass_a, timeout_a, done_b, pass_b, timeout_b;
  logic [30:0] tnum_a, tnum_b;
  logic [31:0] cyc_a, ins_a, cyc_b, ins_b;
`ifdef TOHOST_UART_EN
  logic        tx_a, tx_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tohost_monitor #(
    .TOHOST_ADDR(ADDR), .TIMEOUT_CYCLES(6000), .CNT_W(32)
`ifdef TOHOST_UART_EN
    , .CLKS_PER_BIT(4)
`endif
  ) dut_a (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .retire(retire), .done(done_a), .pass(pass_a), .timeout(timeout_a), .test_num(tnum_a),
    .cycle_count(cyc_a), .instret_count(ins_a)
`ifdef TOHOST_UART_EN
    , .tx(tx_a)
`endif
  );

  tohost_monitor #(
    .TOHOST_ADDR(ADDR), .TIMEOUT_CYCLES(50), .CNT_W(32)
`ifdef TOHOST_UART_EN
    , .CLKS_PER_BIT(4)
`endif
  ) dut_b (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .retire(retire), .done(done_b), .pass(pass_b), .timeout(timeout_b), .test_num(tnum_b),
    .cycle_count(cyc_b), .instret_count(ins_b)
`ifdef TOHOST_UART_EN
    , .tx(tx_b)
`endif
  );

  // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b
  int unsigned lim [2] = '{6000, 50};
  logic        m_done [2];
  logic        m_pass [2];
  logic        m_to   [2];
  logic [30:0] m_tnum [2];
  logic [31:0] m_cyc  [2];
  logic [31:0] m_ins  [2];

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_done[k] = 0; m_pass[k] = 0; m_to[k] = 0;
        m_tnum[k] = 0; m_cyc[k] = 0; m_ins[k] = 0;
      end else if (!m_done[k]) begin
        if (mem_we && mem_addr == ADDR && mem_wdata[0]) begin
          m_done[k] = 1;
          m_pass[k] = (mem_wdata == 32'h1);
          m_tnum[k] = m_pass[k] ? 31'd0 : mem_wdata[31:1];
        end else if (lim[k] != 0 && m_cyc[k] == lim[k] - 1) begin
          m_done[k] = 1;
          m_to[k]   = 1;
        end
        m_cyc[k] = m_cyc[k] + 1;
        m_ins[k] = m_ins[k] + {31'd0, retire};
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    mem_we = 0; mem_addr = '0; mem_wdata = '0; retire = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_a_done"}, 32'(done_a), 32'(m_done[0]));
    chk({tag, "_a_pass"}, 32'(pass_a), 32'(m_pass[0]));
    chk({tag, "_a_to"},   32'(timeout_a), 32'(m_to[0]));
    chk({tag, "_a_tnum"}, 32'(tnum_a), 32'(m_tnum[0]));
    chk({tag, "_a_cyc"},  cyc_a, m_cyc[0]);
    chk({tag, "_a_ins"},  ins_a, m_ins[0]);
    chk({tag, "_b_done"}, 32'(done_b), 32'(m_done[1]));
    chk({tag, "_b_pass"}, 32'(pass_b), 32'(m_pass[1]));
    chk({tag, "_b_to"},   32'(timeout_b), 32'(m_to[1]));
    chk({tag, "_b_tnum"}, 32'(tnum_b), 32'(m_tnum[1]));
    chk({tag, "_b_cyc"},  cyc_b, m_cyc[1]);
    chk({tag, "_b_ins"},  ins_b, m_ins[1]);
  endtask

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ret;
    logic        e_done;
    logic        e_pass;
    logic [30:0] e_tnum;
    logic [31:0] e_cyc;
    logic [31:0] e_ins;
  } vec_t;

  vec_t vecs [10];

`ifdef TOHOST_UART_EN
  task automatic uart_frame_check(input logic [7:0] ch);
    logic [9:0] frame;
    int         w;
    int         lows;
    frame = {1'b1, ch, 1'b0};
    w = 0;
    while (tx_a !== 1'b0 && w < 60) begin
      tick();
      w++;
    end
    chk("uart_start_seen", 32'(tx_a), 32'd0);
    if (tx_a === 1'b0) begin
      for (int b = 0; b < 10; b++) begin
        tick(); tick();
        chk($sformatf("uart_bit%0d", b), 32'(tx_a), 32'(frame[b]));
        tick(); tick();
      end
      lows = 0;
      for (int i = 0; i < 80; i++) begin
        if (tx_a !== 1'b1) lows++;
        tick();
      end
      chk("uart_no_second_frame", 32'(lows), 32'd0);
    end
  endtask
`endif

  initial begin
    vecs[0] = '{1'b1, 1'b0, ADDR,          32'h0,         1'b0, 1'b0, 1'b0, 31'd0, 32'd0, 32'd0};
    vecs[1] = '{1'b0, 1'b1, ADDR,          32'h2,         1'b1, 1'b0, 1'b0, 31'd0, 32'd1, 32'd1};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_1004, 32'h1,         1'b0, 1'b0, 1'b0, 31'd0, 32'd2, 32'd1};
    vecs[3] = '{1'b0, 1'b0, ADDR,          32'h1,         1'b0, 1'b0, 1'b0, 31'd0, 32'd3, 32'd1};
    vecs[4] = '{1'b0, 1'b1, ADDR,          32'h1,         1'b1, 1'b1, 1'b1, 31'd0, 32'd4, 32'd2};
    vecs[5] = '{1'b0, 1'b1, ADDR,          32'hB,         1'b1, 1'b1, 1'b1, 31'd0, 32'd4, 32'd2};
    vecs[6] = '{1'b1, 1'b1, ADDR,          32'h1,         1'b1, 1'b0, 1'b0, 31'd0, 32'd0, 32'd0};
    vecs[7] = '{1'b0, 1'b1, ADDR,          32'hB,         1'b0, 1'b1, 1'b0, 31'd5, 32'd1, 32'd0};
    vecs[8] = '{1'b0, 1'b1, ADDR,          32'h1,         1'b1, 1'b1, 1'b0, 31'd5, 32'd1, 32'd0};
    vecs[9] = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 1'b0, 31'd5, 32'd1, 32'd0};

    // Reset state
    do_reset();
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_timeout", 32'(timeout_a), 32'd0);
    chk("rst_tnum", 32'(tnum_a), 32'd0);
    chk("rst_cyc", cyc_a, 32'd0);
    chk("rst_ins", ins_a, 32'd0);
`ifdef TOHOST_UART_EN
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_tx_b", 32'(tx_b), 32'd1);
`endif

    // Vector table against dut_a
    for (int i = 0; i < 10; i++) begin
      rst = vecs[i].rst; mem_we = vecs[i].we; mem_addr = vecs[i].addr;
      mem_wdata = vecs[i].wdata; retire = vecs[i].ret;
      tick();
      chk($sformatf("vec%0d_done", i), 32'(done_a), 32'(vecs[i].e_done));
      chk($sformatf("vec%0d_pass", i), 32'(pass_a), 32'(vecs[i].e_pass));
      chk($sformatf("vec%0d_tnum", i), 32'(tnum_a), 32'(vecs[i].e_tnum));
      chk($sformatf("vec%0d_cyc", i), cyc_a, vecs[i].e_cyc);
      chk($sformatf("vec%0d_ins", i), ins_a, vecs[i].e_ins);
      chk($sformatf("vec%0d_to", i), 32'(timeout_a), 32'd0);
    end
    rst = 0;
    idle();

    // Pass write at cycle 100
    do_reset();
    for (int i = 0; i < 100; i++) tick();
    chk("p100_pre_done", 32'(done_a), 32'd0);
    mem_we = 1; mem_addr = ADDR; mem_wdata = 32'h1;
    tick();
    idle();
    chk("p100_done", 32'(done_a), 32'd1);
    chk("p100_pass", 32'(pass_a), 32'd1);
    chk("p100_tnum", 32'(tnum_a), 32'd0);
    chk("p100_cyc", cyc_a, 32'd101);
    chk("p100_to", 32'(timeout_a), 32'd0);
`ifdef TOHOST_UART_EN
    uart_frame_check(8'h50);
`endif

    // Watchdog expiry on dut_b, retire on odd cycles
    do_reset();
    for (int i = 0; i < 49; i++) begin
      retire = (i % 2) == 1;
      tick();
    end
    chk("wd_pre_done", 32'(done_b), 32'd0);
    chk("wd_pre_cyc", cyc_b, 32'd49);
    retire = 1;
    tick();
    chk("wd_done", 32'(done_b), 32'd1);
    chk("wd_to", 32'(timeout_b), 32'd1);
    chk("wd_pass", 32'(pass_b), 32'd0);
    chk("wd_cyc", cyc_b, 32'd50);
    chk("wd_ins", ins_b, 32'd25);
    mem_we = 1; mem_addr = ADDR; mem_wdata = 32'h1;
    for (int i = 0; i < 5; i++) tick();
    idle();
    chk("wd_hold_pass", 32'(pass_b), 32'd0);
    chk("wd_hold_cyc", cyc_b, 32'd50);
    chk("wd_hold_ins", ins_b, 32'd25);

    // Hit on the watchdog cycle wins
    do_reset();
    for (int i = 0; i < 49; i++) begin
      retire = (i % 2) == 1;
      tick();
    end
    retire = 1; mem_we = 1; mem_addr = ADDR; mem_wdata = 32'h7;
    tick();
    idle();
    chk("wdhit_done", 32'(done_b), 32'd1);
    chk("wdhit_to", 32'(timeout_b), 32'd0);
    chk("wdhit_pass", 32'(pass_b), 32'd0);
    chk("wdhit_tnum", 32'(tnum_b), 32'd3);
    chk("wdhit_cyc", cyc_b, 32'd50);
    chk("wdhit_ins", ins_b, 32'd25);

    // One-cycle reset mid-run
    do_reset();
    for (int i = 0; i < 30; i++) begin
      retire = $urandom_range(0, 1) == 1;
      tick();
    end
    idle();
    rst = 1;
    tick();
    rst = 0;
    chk("mid_cyc", cyc_a, 32'd0);
    chk("mid_ins", ins_a, 32'd0);
    chk("mid_done", 32'(done_a), 32'd0);
    tick();
    chk("mid_restart_cyc", cyc_a, 32'd1);
    chk("mid_restart_cyc_b", cyc_b, 32'd1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 299) == 0);
      mem_we = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 15))
        0:       mem_addr = ADDR;
        1:       mem_addr = ADDR + 32'd4;
        2:       mem_addr = ADDR ^ 32'h8000_0000;
        default: mem_addr = $urandom();
      endcase
      case ($urandom_range(0, 3))
        0:       mem_wdata = 32'h1;
        1:       mem_wdata = {$urandom_range(0, 255), 1'b1};
        default: mem_wdata = $urandom();
      endcase
      retire = $urandom_range(0, 1) == 1;
      tick();
      chk_model($sformatf("rnd%0d", i));
    end
    rst = 0;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1);
  end

endmodule
